// File: rtl/rect_sprite_rasterizer.sv
// Rectangle sprite rasterizer: walks a small attribute table and
// emits one framebuffer pixel write per clock, clipped to the screen.
module rect_sprite_rasterizer #(
  parameter int BUFFER_WIDTH      = 160,
  parameter int BUFFER_HEIGHT     = 120,
  parameter int BUFFER_DATA_WIDTH = 12,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH*BUFFER_HEIGHT),
  parameter int MAX_SPRITES       = 8,
  parameter int SIZE_WIDTH        = 6,
  localparam int XW = $clog2(BUFFER_WIDTH),
  localparam int YW = $clog2(BUFFER_HEIGHT),
  localparam int IW = $clog2(MAX_SPRITES)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         attr_we,
  input  logic [IW-1:0]                attr_idx,
  input  logic                         attr_valid,
  input  logic [XW-1:0]                attr_x,
  input  logic [YW-1:0]                attr_y,
  input  logic [SIZE_WIDTH-1:0]        attr_w,
  input  logic [SIZE_WIDTH-1:0]        attr_h,
  input  logic [BUFFER_DATA_WIDTH-1:0] attr_color,
  input  logic                         draw_start,
  output logic                         draw_done,
  output logic                         write_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] write_addr,
  output logic [BUFFER_DATA_WIDTH-1:0] write_data
);

  localparam int AW = BUFFER_ADDR_WIDTH;
  localparam int SW = SIZE_WIDTH;
  localparam int DW = BUFFER_DATA_WIDTH;
  localparam logic [XW:0] XLIM = (XW+1)'(BUFFER_WIDTH);
  localparam logic [YW:0] YLIM = (YW+1)'(BUFFER_HEIGHT);
  localparam logic [AW-1:0] ASTEP = AW'(BUFFER_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAW, S_DONE, S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic          tv [MAX_SPRITES];
  logic [XW-1:0] tx [MAX_SPRITES];
  logic [YW-1:0] ty [MAX_SPRITES];
  logic [SW-1:0] tw [MAX_SPRITES];
  logic [SW-1:0] th [MAX_SPRITES];
  logic [DW-1:0] tc [MAX_SPRITES];

  logic [IW-1:0] idx_q;
  logic [XW-1:0] wx_q;
  logic [YW-1:0] wy_q;
  logic [SW-1:0] ww_q, wh_q, col_q, row_q;
  logic [DW-1:0] wc_q;
  logic [AW-1:0] rowbase_q;

  logic [XW:0] px;
  logic [YW:0] py;
  logic        inb, col_last, row_last, idx_last, skip;

  assign px       = {1'b0, wx_q} + (XW+1)'(col_q);
  assign py       = {1'b0, wy_q} + (YW+1)'(row_q);
  assign inb      = (px < XLIM) && (py < YLIM);
  assign col_last = col_q == ww_q - SW'(1);
  assign row_last = row_q == wh_q - SW'(1);
  assign idx_last = idx_q == IW'(MAX_SPRITES-1);
  assign skip     = !tv[idx_q] || tw[idx_q] == '0 || th[idx_q] == '0;

  // Attribute table, writable at any time.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MAX_SPRITES; i++) begin
        tv[i] <= 1'b0;
        tx[i] <= '0;
        ty[i] <= '0;
        tw[i] <= '0;
        th[i] <= '0;
        tc[i] <= '0;
      end
    end else if (attr_we) begin
      tv[attr_idx] <= attr_valid;
      tx[attr_idx] <= attr_x;
      ty[attr_idx] <= attr_y;
      tw[attr_idx] <= attr_w;
      th[attr_idx] <= attr_h;
      tc[attr_idx] <= attr_color;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; dropping draw_start aborts a pass.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (draw_start) state_d = S_LOAD;
      S_LOAD: begin
        if (!draw_start)   state_d = S_IDLE;
        else if (!skip)    state_d = S_DRAW;
        else if (idx_last) state_d = S_DONE;
      end
      S_DRAW: begin
        if (!draw_start)
          state_d = S_IDLE;
        else if (col_last && row_last)
          state_d = idx_last ? S_DONE : S_LOAD;
      end
      S_DONE: state_d = S_WAIT;
      S_WAIT: if (!draw_start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Working copy of the current sprite and the raster walk counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q     <= '0;
      wx_q      <= '0;
      wy_q      <= '0;
      ww_q      <= '0;
      wh_q      <= '0;
      wc_q      <= '0;
      col_q     <= '0;
      row_q     <= '0;
      rowbase_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: idx_q <= '0;
        S_LOAD: begin
          wx_q      <= tx[idx_q];
          wy_q      <= ty[idx_q];
          ww_q      <= tw[idx_q];
          wh_q      <= th[idx_q];
          wc_q      <= tc[idx_q];
          col_q     <= '0;
          row_q     <= '0;
          rowbase_q <= AW'(ty[idx_q] * BUFFER_WIDTH);
          if (skip && !idx_last) idx_q <= idx_q + IW'(1);
        end
        S_DRAW: begin
          if (col_last) begin
            col_q     <= '0;
            row_q     <= row_q + SW'(1);
            rowbase_q <= rowbase_q + ASTEP;
            if (row_last && !idx_last) idx_q <= idx_q + IW'(1);
          end else begin
            col_q <= col_q + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered framebuffer write port and completion pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      draw_done  <= 1'b0;
    end else begin
      write_en  <= (state_q == S_DRAW) && draw_start && inb;
      draw_done <= state_q == S_DONE;
      if (state_q == S_DRAW) begin
        write_addr <= rowbase_q + AW'(px);
        write_data <= wc_q;
      end
    end
  end

endmodule
